// File: rtl/wakeup_pipe.sv
// wakeup_pipe: fixed-latency (1-4 cycle) wakeup generator behind the issue queue.
// Four entries rotate under a free-running pointer; entry k owns broadcast lane k.
module wakeup_pipe #(
    parameter int unsigned WIDTH_REG = 5,
    parameter int unsigned WIDTH_BRM = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    input  logic [WIDTH_REG-1:0]   i_rd,
    input  logic                   i_wen,
    input  logic [1:0]             i_lat,
    input  logic [WIDTH_BRM-1:0]   i_brmask,
    input  logic [WIDTH_BRM-1:0]   i_BrKill,
    output logic [4*WIDTH_REG-1:0] o_wdest4x,
    output logic [2:0]             o_inflight
);

    logic [3:0]                valid_q, valid_d;
    logic [3:0][WIDTH_REG-1:0] rd_q, rd_d;
    logic [3:0][1:0]           cnt_q, cnt_d;
    logic [3:0][WIDTH_BRM-1:0] brm_q, brm_d;
    logic [3:0][WIDTH_REG-1:0] lane_q, lane_d;
    logic [1:0]                ptr_q, ptr_d;
    logic [2:0]                inflight_q, inflight_d;
    logic                      accept;

    always_comb begin
        accept  = i_valid & i_wen & (i_rd != '0) & ~|(i_brmask & i_BrKill);
        valid_d = valid_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        brm_d   = brm_q;
        lane_d  = '0;
        ptr_d   = ptr_q + 2'd1;

        for (int unsigned k = 0; k < 4; k++) begin
            if (valid_q[k]) begin
                if (|(brm_q[k] & i_BrKill)) begin
                    valid_d[k] = 1'b0;
                end else if (cnt_q[k] == 2'd1) begin
                    lane_d[k]  = rd_q[k];
                    valid_d[k] = 1'b0;
                end else begin
                    cnt_d[k] = cnt_q[k] - 2'd1;
                end
            end
        end

        // Entry ptr has always drained by the time the pointer returns, so the
        // new issue can claim its lane/entry outright.
        if (accept) begin
            if (i_lat == 2'd0) begin
                lane_d[ptr_q] = i_rd;
            end else begin
                valid_d[ptr_q] = 1'b1;
                rd_d[ptr_q]    = i_rd;
                cnt_d[ptr_q]   = i_lat;
                brm_d[ptr_q]   = i_brmask;
            end
        end

        inflight_d = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            inflight_d = inflight_d + {2'b00, valid_d[k]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q    <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            brm_q      <= '0;
            lane_q     <= '0;
            ptr_q      <= '0;
            inflight_q <= '0;
        end else begin
            valid_q    <= valid_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            brm_q      <= brm_d;
            lane_q     <= lane_d;
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
        end
    end

    assign o_wdest4x  = lane_q;
    assign o_inflight = inflight_q;

endmodule

// File: tb/tb_wakeup_pipe.sv
// Bench for wakeup_pipe: event-list model of scheduled broadcasts, directed
// literal checks, then randomized issue/kill traffic with a mid-run reset.
module tb_wakeup_pipe;

    localparam int unsigned WR = 5;
    localparam int unsigned WB = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic          wen   = 1'b0;
    logic [WR-1:0] rd    = '0;
    logic [1:0]    lat   = '0;
    logic [WB-1:0] bm    = '0;
    logic [WB-1:0] kill  = '0;
    logic [4*WR-1:0] wdest;
    logic [2:0]      inflight;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wakeup_pipe #(.WIDTH_REG(WR), .WIDTH_BRM(WB)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_rd       (rd),
        .i_wen      (wen),
        .i_lat      (lat),
        .i_brmask   (bm),
        .i_BrKill   (kill),
        .o_wdest4x  (wdest),
        .o_inflight (inflight)
    );

    // Model: each accepted issue is an event "tag appears on lane L in cycle D".
    typedef struct {
        bit            v;
        int            due;
        int            lane;
        logic [WR-1:0] rd;
        logic [WB-1:0] bm;
    } ev_t;

    ev_t ev[16];
    int  cyc         = 0;
    bit  live_at_pos = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        foreach (ev[i]) ev[i].v = 1'b0;
        cyc = 0;
    endtask

    // Advance the model across the edge ending cycle cyc, using that cycle's inputs.
    task automatic model_step();
        bit acc;
        bit placed;
        foreach (ev[i]) if (ev[i].v && ev[i].due <= cyc) ev[i].v = 1'b0;
        foreach (ev[i]) if (ev[i].v && (ev[i].bm & kill) != '0) ev[i].v = 1'b0;
        acc    = valid && wen && (rd != '0) && ((bm & kill) == '0);
        placed = 1'b0;
        if (acc) begin
            for (int i = 0; i < 16; i++) begin
                if (!placed && !ev[i].v) begin
                    ev[i]  = '{1'b1, cyc + int'(lat) + 1, cyc % 4, rd, bm};
                    placed = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    task automatic model_compare();
        logic [4*WR-1:0] ew;
        int ei;
        ew = '0;
        ei = 0;
        foreach (ev[i]) begin
            if (ev[i].v) begin
                if (ev[i].due == cyc) ew[ev[i].lane*WR +: WR] = ev[i].rd;
                else if (ev[i].due > cyc) ei++;
            end
        end
        chk("model_lanes", 32'(wdest), 32'(ew));
        chk("model_inflight", 32'(inflight), ei);
    endtask

    initial forever begin
        @(posedge clk);
        live_at_pos = rst_n;
    end

    initial forever begin
        @(negedge rst_n);
        model_clear();
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) model_clear();
        else if (live_at_pos) model_step();
        model_compare();
    end

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input int r, input bit w, input int l,
                          input int b, input int k);
        #1;
        valid = v;
        rd    = WR'(r);
        wen   = w;
        lat   = 2'(l);
        bm    = WB'(b);
        kill  = WB'(k);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0; wen = 1'b0; rd = '0; lat = '0; bm = '0; kill = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Reset, then idle
        do_reset();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            chk("t1_lanes", 32'(wdest), 0);
            chk("t1_inflight", 32'(inflight), 0);
            idle();
        end

        // Single issue per latency
        do_reset();
        next_cycle(); set_in(1, 7, 1, 0, 0, 0);
        next_cycle(); chk("t2_lat1_lane0", 32'(wdest), 32'h00007); set_in(1, 9, 1, 3, 0, 0);
        next_cycle(); chk("t2_c2_lanes", 32'(wdest), 0); chk("t2_c2_inflight", 32'(inflight), 1); idle();
        next_cycle(); chk("t2_c3_inflight", 32'(inflight), 1); idle();
        next_cycle(); chk("t2_c4_inflight", 32'(inflight), 1); chk("t2_c4_lanes", 32'(wdest), 0); idle();
        next_cycle(); chk("t2_lat4_lane1", 32'(wdest), 32'h00120); chk("t2_c5_inflight", 32'(inflight), 0); idle();
        next_cycle(); chk("t2_c6_lanes", 32'(wdest), 0); idle();

        // Four completions landing in the same cycle
        do_reset();
        next_cycle(); set_in(1, 3, 1, 3, 0, 0);
        next_cycle(); set_in(1, 4, 1, 2, 0, 0);
        next_cycle(); set_in(1, 5, 1, 1, 0, 0);
        next_cycle(); chk("t3_c3_inflight", 32'(inflight), 3); set_in(1, 6, 1, 0, 0, 0);
        next_cycle(); chk("t3_all_lanes", 32'(wdest), 32'h31483); chk("t3_c4_inflight", 32'(inflight), 0); idle();
        next_cycle(); chk("t3_c5_lanes", 32'(wdest), 0); idle();

        // Branch kill of an in-flight entry and of the incoming issue
        do_reset();
        next_cycle(); set_in(1, 12, 1, 3, 3'b010, 0);
        next_cycle(); chk("t4_c1_inflight", 32'(inflight), 1); idle();
        next_cycle(); chk("t4_c2_inflight", 32'(inflight), 1); set_in(0, 0, 0, 0, 0, 3'b010);
        next_cycle(); chk("t4_c3_inflight", 32'(inflight), 0); idle();
        next_cycle(); chk("t4_c4_lanes", 32'(wdest), 0); idle();
        next_cycle(); set_in(1, 13, 1, 0, 3'b001, 3'b001);
        next_cycle(); chk("t4_selfkill_lanes", 32'(wdest), 0); chk("t4_selfkill_inflight", 32'(inflight), 0);
        set_in(1, 13, 1, 2, 3'b001, 3'b001);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            chk("t4_selfkill2_lanes", 32'(wdest), 0);
            chk("t4_selfkill2_inflight", 32'(inflight), 0);
            idle();
        end

        // Filtering: tag 0 or no register write
        do_reset();
        for (int l = 0; l < 4; l++) begin
            next_cycle(); chk("t5_lanes", 32'(wdest), 0); chk("t5_inflight", 32'(inflight), 0);
            set_in(1, 0, 1, l, 0, 0);
            next_cycle(); chk("t5_lanes", 32'(wdest), 0); chk("t5_inflight", 32'(inflight), 0);
            set_in(1, 17, 0, l, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            next_cycle(); chk("t5_tail_lanes", 32'(wdest), 0); chk("t5_tail_inflight", 32'(inflight), 0);
            idle();
        end

        // Async reset mid-flight
        do_reset();
        next_cycle(); set_in(1, 20, 1, 3, 0, 0);
        next_cycle(); idle();
        next_cycle(); chk("t6_pre_inflight", 32'(inflight), 1);
        #2;
        rst_n = 1'b0;
        valid = 1'b0; wen = 1'b0; rd = '0; lat = '0; bm = '0; kill = '0;
        #1;
        chk("t6_async_lanes", 32'(wdest), 0);
        chk("t6_async_inflight", 32'(inflight), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            chk("t6_post_lanes", 32'(wdest), 0);
            chk("t6_post_inflight", 32'(inflight), 0);
            idle();
        end

        // Randomized traffic against the event model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            next_cycle();
            if (n == 300) begin
                #3 rst_n = 1'b0;
                valid = 1'b0; wen = 1'b0; rd = '0; lat = '0; bm = '0; kill = '0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                set_in($urandom_range(0, 3) != 0,
                       ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31)),
                       $urandom_range(0, 6) != 0,
                       int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 7)),
                       ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0);
            end
        end
        next_cycle(); idle();
        repeat (5) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
